regbank_mp: RTL and testbench

REGBANK_MP -- requirements
Module: regbank_mp

---
 rtl/regbank_mp_pkg.sv | 18 +
 rtl/regbank_sb.sv | 42 ++++
 rtl/regbank_mp.sv | 138 +++++++++++++
 tb/tb_regbank_mp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_mp_pkg.sv
// regbank_mp_pkg -- shared definitions for the multi-port register bank.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   rb_state_e           : bank state (INIT sweep, RUN)
//   reg_addr_t           : register address type for the default bank size
package regbank_mp_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rb_state_e;

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regbank_sb.sv
// regbank_sb -- busy scoreboard, one bit per register.
//   clk, rst_n     : clock, async active-low reset (all bits clear)
//   clk_en         : global enable; nothing changes when low
//   clr            : clear every bit (wins over everything)
//   clr_en/addr    : NWR clear ports (register written back)
//   set_en/addr    : set port (producer issued); set beats clear on the
//                    same register, and bit 0 never sets
//   busy           : registered busy vector
module regbank_sb
  import regbank_mp_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_en,
  input  logic                             clr,
  input  logic [NWR-1:0]                   clr_en,
  input  logic [NWR-1:0][$clog2(NREGS)-1:0] clr_addr,
  input  logic                             set_en,
  input  logic [$clog2(NREGS)-1:0]         set_addr,
  output logic [NREGS-1:0]                 busy
);

  logic [NREGS-1:0] busy_nxt;

  // Clears first, then the set, so a same-cycle issue keeps the bit busy.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++)
      if (clr_en[i]) busy_nxt[clr_addr[i]] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      busy <= '0;
    else if (clk_en) busy <= clr ? '0 : busy_nxt;
  end

endmodule

// File: rtl/regbank_mp.sv
// regbank_mp -- multi-port register file with x0 hard-wired to zero, a
// self-clearing INIT sweep and a busy scoreboard for issued producers.
//   clk, rst_n      : clock, async active-low reset
//   clk_en          : global clock enable
//   clr             : re-zero bank and clear scoreboard (RUN only)
//   rd_addr/rd_data : NRD combinational read ports
//   rd_busy         : scoreboard bit of each read address
//   wr_en/addr/data : NWR write ports, highest index wins on collision
//   iss_en/iss_addr : mark destination busy
//   ready           : high in RUN; writes/issues only accepted then
// Build option: define REGBANK_FWD_EN to forward same-cycle writes to reads.
module regbank_mp
  import regbank_mp_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clk_en,
  input  logic                              clr,
  input  logic [NRD-1:0][$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD-1:0][XLEN-1:0]          rd_data,
  output logic [NRD-1:0]                    rd_busy,
  input  logic [NWR-1:0]                    wr_en,
  input  logic [NWR-1:0][$clog2(NREGS)-1:0] wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]          wr_data,
  input  logic                              iss_en,
  input  logic [$clog2(NREGS)-1:0]          iss_addr,
  output logic                              ready
);

  localparam int            AW   = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  rb_state_e                  state;
  logic [AW-1:0]              cnt;
  logic [NREGS-1:0][XLEN-1:0] mem;
  logic [NREGS-1:0]           busy;
  logic                       run;
  logic                       run_go;
  logic [NWR-1:0]             wr_act;

  assign run    = (state == ST_RUN);
  // A clr cycle swallows the writes and issues presented with it.
  assign run_go = run & ~clr;

  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign wr_act[i] = wr_en[i] & run_go & (wr_addr[i] != '0);
  end

  // Sweep counter starts at 1: x0 is never stored, so NREGS-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= ONE;
      ready <= 1'b0;
    end else if (clk_en) begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_RUN: begin
          if (clr) begin
            state <= ST_INIT;
            cnt   <= ONE;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= ONE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; the INIT sweep zeroes it. Later ports overwrite
  // earlier ones in the loop, giving the highest index priority.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (!run) begin
        mem[cnt] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++)
          if (wr_act[i]) mem[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [XLEN-1:0] d;
    logic [AW-1:0]   a;

    assign a = rd_addr[p];

    // During the sweep, entries below the counter are already zero even if
    // the array still holds older contents for the rest.
    always_comb begin
      d = mem[a];
      if (a == '0 || (!run && a < cnt)) d = '0;
`ifdef REGBANK_FWD_EN
      else if (clk_en) begin
        for (int i = 0; i < NWR; i++)
          if (wr_act[i] && wr_addr[i] == a) d = wr_data[i];
      end
`endif
    end

    assign rd_data[p] = d;
    assign rd_busy[p] = busy[a] & (a != '0);
  end

  regbank_sb #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .clr      (run & clr),
    .clr_en   (wr_act),
    .clr_addr (wr_addr),
    .set_en   (iss_en & run_go),
    .set_addr (iss_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp -- directed table, corner sequences and random traffic for
// regbank_mp, checked against a behavioural array model of the bank.
module tb_regbank_mp;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     clk_en, clr, iss_en, ready;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic [AW-1:0]            iss_addr;

  always #5 clk = ~clk;

  regbank_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clr(clr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .ready(ready)
  );

  int nvec = 0, nerr = 0;

  // Behavioural model: register values, which ones hold a defined value,
  // busy flags, and sweep progress.
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_known [NREGS];
  bit              m_busy [NREGS];
  bit              m_init;
  int              m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!clk_en) return;
    if (m_init) begin
      m_reg[m_cnt] = '0;
      m_known[m_cnt] = 1'b1;
      if (m_cnt == NREGS - 1) m_init = 1'b0;
      else m_cnt++;
    end else if (clr) begin
      m_init = 1'b1;
      m_cnt  = 1;
      for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i] != 0) begin
          m_reg[wr_addr[i]]   = wr_data[i];
          m_known[wr_addr[i]] = 1'b1;
          m_busy[wr_addr[i]]  = 1'b0;
        end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_read(input int a, output logic [31:0] v, output bit known);
    v = '0;
    known = 1'b1;
    if (a == 0) return;
    if (m_init && a < m_cnt) return;
    v = m_reg[a];
    known = m_known[a];
`ifdef REGBANK_FWD_EN
    if (!m_init && clk_en && !clr)
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i] == a) begin
          v = wr_data[i];
          known = 1'b1;
        end
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] v;
    bit          k;
    chk({tag, ".ready"}, {31'b0, ready}, {31'b0, !m_init});
    for (int p = 0; p < NRD; p++) begin
      model_read(int'(rd_addr[p]), v, k);
      if (k) chk($sformatf("%s.rd%0d[x%0d]", tag, p, rd_addr[p]), rd_data[p], v);
      chk($sformatf("%s.busy%0d[x%0d]", tag, p, rd_addr[p]), {31'b0, rd_busy[p]},
          {31'b0, (rd_addr[p] != 0) && m_busy[rd_addr[p]]});
    end
  endtask

  task automatic idle();
    clk_en = 1'b1; clr = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    m_init = 1'b1;
    m_cnt  = 1;
    for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    chk("rst.ready", {31'b0, ready}, 32'd0);
    chk("rst.busy", {30'b0, rd_busy}, 32'd0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra;
    logic [31:0] exp_d;
    logic        exp_b;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n, total;
    for (int r = 0; r < NREGS; r++) begin
      m_reg[r] = '0; m_known[r] = (r == 0); m_busy[r] = 1'b0;
    end
    idle();

    // Sweep after reset: 31 enabled cycles, then everything reads zero.
    do_reset();
    wait_ready(n);
    chk("sweep.cycles", n, 31);
    for (int r = 0; r < NREGS; r++) begin
      rd_addr[0] = AW'(r);
      rd_addr[1] = AW'(NREGS - 1 - r);
      #1;
      chk($sformatf("sweep.x%0d", r), rd_data[0], 32'd0);
      check_outputs("sweep");
    end

    // {we, wa0, wa1, wd0, wd1, ie, ia, ra, data after edge, busy after edge}
    tbl[0] = '{2'b11, 5'd5,  5'd5,  32'hAAAA0000, 32'h5555FFFF, 1'b0, 5'd0,  5'd5,  32'h5555FFFF, 1'b0};
    tbl[1] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd7,  5'd7,  32'h0,        1'b1};
    tbl[2] = '{2'b01, 5'd7,  5'd0,  32'h12,       32'h0,        1'b0, 5'd0,  5'd7,  32'h12,       1'b0};
    tbl[3] = '{2'b10, 5'd0,  5'd7,  32'h0,        32'h34,       1'b1, 5'd7,  5'd7,  32'h34,       1'b1};
    tbl[4] = '{2'b11, 5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  32'h0,        1'b0};
    tbl[5] = '{2'b01, 5'd3,  5'd0,  32'h33,       32'h0,        1'b0, 5'd0,  5'd3,  32'h33,       1'b0};
    tbl[6] = '{2'b11, 5'd31, 5'd30, 32'hDEADBEEF, 32'h1,        1'b0, 5'd0,  5'd31, 32'hDEADBEEF, 1'b0};
    tbl[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd31, 5'd31, 32'hDEADBEEF, 1'b1};
    tbl[8] = '{2'b11, 5'd31, 5'd31, 32'h0,        32'h7,        1'b0, 5'd0,  5'd31, 32'h7,        1'b0};

    for (int k = 0; k < 9; k++) begin
      wr_en = tbl[k].we;
      wr_addr[0] = tbl[k].wa0; wr_addr[1] = tbl[k].wa1;
      wr_data[0] = tbl[k].wd0; wr_data[1] = tbl[k].wd1;
      iss_en = tbl[k].ie; iss_addr = tbl[k].ia;
      rd_addr[0] = tbl[k].ra; rd_addr[1] = tbl[k].ra;
      #1;
      check_outputs($sformatf("vec%0d.pre", k));
`ifdef REGBANK_FWD_EN
      if (tbl[k].we != 0 && tbl[k].ra != 0)
        chk($sformatf("vec%0d.fwd", k), rd_data[0], tbl[k].exp_d);
`endif
      tick();
      wr_en = '0; iss_en = 1'b0;
      #1;
      chk($sformatf("vec%0d.data", k), rd_data[0], tbl[k].exp_d);
      chk($sformatf("vec%0d.busy", k), {31'b0, rd_busy[0]}, {31'b0, tbl[k].exp_b});
      check_outputs($sformatf("vec%0d.post", k));
    end

    // clr in RUN, stalled mid-sweep by clk_en=0 for 5 cycles.
    idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 32'h2020;
    tick();
    idle();
    clr = 1'b1;
    wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h44;
    iss_en = 1'b1; iss_addr = 5'd10;
    tick();
    idle();
    #1;
    chk("clr.ready", {31'b0, ready}, 32'd0);
    total = 0;
    repeat (10) begin tick(); total++; end
    clk_en = 1'b0;
    rd_addr[0] = 5'd2; rd_addr[1] = 5'd20;
    repeat (5) begin
      wr_en = 2'b01; wr_addr[0] = 5'd2; wr_data[0] = 32'hBAD;
      iss_en = 1'b1; iss_addr = 5'd2;
      #1;
      check_outputs("stall");
      tick();
      total++;
    end
    idle();
    wait_ready(n);
    chk("clr.cycles", total + n, 36);
    for (int r = 0; r < NREGS; r++) begin
      rd_addr[0] = AW'(r);
      #1;
      chk($sformatf("clr.x%0d", r), {rd_data[0][30:0], rd_busy[0]}, 32'd0);
    end

    // Reset pulse while the sweep counter sits at 10.
    clr = 1'b1;
    tick();
    idle();
    repeat (9) tick();
    do_reset();
    wait_ready(n);
    chk("rstmid.cycles", n, 31);

    // Random traffic on a narrow address window to force collisions.
    repeat (3000) begin
      clk_en = ($urandom % 8) != 0;
      clr = ($urandom % 150) == 0;
      wr_en = NWR'($urandom);
      iss_en = ($urandom % 3) == 0;
      iss_addr = AW'($urandom_range(0, 7));
      for (int i = 0; i < NWR; i++) begin
        wr_addr[i] = AW'($urandom_range(0, 7));
        wr_data[i] = $urandom;
      end
      for (int p = 0; p < NRD; p++) rd_addr[p] = AW'($urandom_range(0, 7));
      #1;
      check_outputs("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
